// File: rtl/sequencer_pkg.sv
// Shared state encoding and instruction indices for the loop-driven instruction sequencer.
package sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT0 = 3'd1,
      INIT1 = 3'd2,
      CHECK = 3'd3,
      LOOP2 = 3'd4,
      LOOP3 = 3'd5,
      FIN   = 3'd6
   } seq_state_t;

   localparam logic [1:0] INSTR_LOAD0 = 2'd0;
   localparam logic [1:0] INSTR_LOAD1 = 2'd1;
   localparam logic [1:0] INSTR_STEP2 = 2'd2;
   localparam logic [1:0] INSTR_STEP3 = 2'd3;

   // Instruction index issued in a given state; non-issuing states drive index 0.
   function automatic logic [1:0] instr_of(input seq_state_t s);
      logic [1:0] sel;
      sel = INSTR_LOAD0;
      case (s)
         INIT0:   sel = INSTR_LOAD0;
         INIT1:   sel = INSTR_LOAD1;
         LOOP2:   sel = INSTR_STEP2;
         LOOP3:   sel = INSTR_STEP3;
         default: sel = INSTR_LOAD0;
      endcase
      return sel;
   endfunction

   function automatic logic issues(input seq_state_t s);
      return (s == INIT0) || (s == INIT1) || (s == LOOP2) || (s == LOOP3);
   endfunction

endpackage

// File: rtl/seq_pc_counter.sv
// Program counter for the sequencer: cleared on run start, advanced by PC_STEP per issued
// instruction, wrapping naturally at 12 bits.
module seq_pc_counter #(
   parameter int PC_STEP = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        enable,
   output logic [11:0] pc
);

   localparam logic [11:0] STEP = 12'(PC_STEP % 4096);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc <= '0;
      end else if (clear) begin
         pc <= '0;
      end else if (enable) begin
         pc <= pc + STEP;
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Issues the two init instructions, then repeats the two-instruction loop body while the
// datapath reports lt, bounded by MAX_ITER iterations.
//
// state | meaning
// IDLE  | waiting for start; iter_count/timeout hold last run's result
// INIT0 | issue instruction 0
// INIT1 | issue instruction 1
// CHECK | no issue; sample lt and the iteration cap
// LOOP2 | issue instruction 2
// LOOP3 | issue instruction 3, count one completed iteration
// FIN   | one-cycle done pulse, then back to IDLE
module instr_sequencer
   import sequencer_pkg::*;
#(
   parameter int MAX_ITER = 255,
   parameter int PC_STEP  = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        lt,
   output logic [1:0]  instr_sel,
   output logic        instr_valid,
   output logic [11:0] pc,
   output logic        busy,
   output logic        done,
   output logic [7:0]  iter_count,
   output logic        timeout
);

   localparam logic [7:0] ITER_CAP = 8'(MAX_ITER);

   seq_state_t state, state_nx;
   logic       accept;
   logic       iter_inc;
   logic       set_timeout;
   logic       at_cap;

   assign at_cap = (iter_count == ITER_CAP);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      accept      = 1'b0;
      iter_inc    = 1'b0;
      set_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = INIT0;
               accept   = 1'b1;
            end
         end
         INIT0: state_nx = INIT1;
         INIT1: state_nx = CHECK;
         CHECK: begin
            if (!lt) begin
               state_nx = FIN;
            end else if (at_cap) begin
               state_nx    = FIN;
               set_timeout = 1'b1;
            end else begin
               state_nx = LOOP2;
            end
         end
         LOOP2: state_nx = LOOP3;
         LOOP3: begin
            state_nx = CHECK;
            iter_inc = 1'b1;
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are pure decodes of the state register so lt/start never reach them directly.
   assign instr_valid = issues(state);
   assign instr_sel   = instr_of(state);
   assign busy        = (state != IDLE);
   assign done        = (state == FIN);

   // LOOP3 is only reachable after CHECK saw iter_count below the cap, so this cannot wrap.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         iter_count <= '0;
         timeout    <= 1'b0;
      end else if (accept) begin
         iter_count <= '0;
         timeout    <= 1'b0;
      end else begin
         if (iter_inc) begin
            iter_count <= iter_count + 8'd1;
         end
         if (set_timeout) begin
            timeout <= 1'b1;
         end
      end
   end

   seq_pc_counter #(
      .PC_STEP (PC_STEP)
   ) u_pc (
      .clock  (clock),
      .reset  (reset),
      .clear  (accept),
      .enable (instr_valid),
      .pc     (pc)
   );

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter MAX_ITER, default 255: loop-iteration cap, legal range 1..255.
REQ-002 SHALL have parameter PC_STEP, default 1: pc increment per issued instruction.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin one program run.
REQ-006 SHALL have port lt, input, 1 bit: datapath compare flag, 1 when registers[1] < registers[2].
REQ-007 SHALL have port instr_sel, output, 2 bits: instruction index driven to the datapath i input.
REQ-008 SHALL have port instr_valid, output, 1 bit: instr_sel is issued this cycle.
REQ-009 SHALL have port pc, output, 12 bits: address of the issued instruction.
REQ-010 SHALL have port busy, output, 1 bit: a run is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-012 SHALL have port iter_count, output, 8 bits: completed loop iterations in the current or last run.
REQ-013 SHALL have port timeout, output, 1 bit: last run ended on the MAX_ITER cap.

Function
REQ-014 SHALL implement the states IDLE, INIT0, INIT1, CHECK, LOOP2, LOOP3 and FIN.
REQ-015 SHALL, in IDLE with start=1, go to INIT0, clear pc, iter_count and timeout, and set busy=1 from the next cycle.
REQ-016 SHALL ignore start in every state other than IDLE, with no restart and no queuing.
REQ-017 SHALL issue instr_sel=0 in INIT0 and instr_sel=1 in INIT1, with instr_valid=1 in both; INIT0 always goes to INIT1 and INIT1 always goes to CHECK.
REQ-018 SHALL, in CHECK, set instr_valid=0 and sample lt, which the datapath must present after the previous instruction's write-back.
REQ-019 SHALL, in CHECK with lt=1 and iter_count<MAX_ITER, go to LOOP2.
REQ-020 SHALL, in CHECK with lt=1 and iter_count==MAX_ITER, go to FIN and set timeout=1.
REQ-021 SHALL, in CHECK with lt=0, go to FIN with timeout left at 0.
REQ-022 SHALL issue instr_sel=2 in LOOP2 and instr_sel=3 in LOOP3, with instr_valid=1 in both; LOOP2 goes to LOOP3, and LOOP3 increments iter_count and goes to CHECK.
REQ-023 SHALL, in FIN, assert done=1 for exactly one cycle, drop busy, and return to IDLE.
REQ-024 SHALL advance pc by PC_STEP after every cycle with instr_valid=1, wrapping modulo 4096, and hold pc otherwise.
REQ-025 SHALL drive instr_sel=0 whenever instr_valid=0.
REQ-026 SHALL keep iter_count and timeout held from FIN until the next accepted start.
REQ-027 SHALL never let iter_count exceed MAX_ITER, so iter_count cannot wrap.
REQ-028 SHALL make every output a registered value or a pure decode of the state register, with no combinational path from lt or start to any output.

Reset
REQ-029 SHALL, on reset=1 and independent of clock, force state=IDLE, instr_sel=0, instr_valid=0, pc=0, busy=0, done=0, iter_count=0 and timeout=0.
REQ-030 SHALL, on reset mid-run, abort immediately with no done pulse; the first start after reset is deasserted SHALL be accepted normally.
REQ-031 SHALL release reset such that the first rising clock edge with reset=0 can accept start.

Structure
REQ-032 SHALL define the state encoding and the instruction-index constants INSTR_LOAD0=0, INSTR_LOAD1=1, INSTR_STEP2=2 and INSTR_STEP3=3 in a shared package, sequencer_pkg.
REQ-033 SHALL place the pc register and its wrap arithmetic in one sub-module, seq_pc_counter, with ports clock, reset, clear, enable and pc[11:0].
REQ-034 SHALL keep the FSM, iteration counter and output decode in instr_sequencer.

Verification
REQ-035 SHALL verify the no-loop run: start pulse, lt=0 at the first CHECK -> instr_sel sequence 0,1; pc values 0,1; done pulse 4 cycles after start; iter_count=0; timeout=0.
REQ-036 SHALL verify the three-iteration run: lt=1 at the first three CHECKs and 0 at the fourth -> instr_sel sequence 0,1,2,3,2,3,2,3; final pc=8; iter_count=3; timeout=0.
REQ-037 SHALL verify the iteration cap: MAX_ITER=4, lt held at 1 -> exactly 4 loop pairs issued; done pulse; iter_count=4; timeout=1.
REQ-038 SHALL verify pc wrap: PC_STEP=1000, lt=1 for 2 CHECKs -> pc sequence 0,1000,2000,3000,4000,904.
REQ-039 SHALL verify reset during LOOP2 -> all outputs read 0 in the same cycle, no done pulse, and the next start produces instr_sel=0 with pc=0.
REQ-040 SHALL verify a start pulse during LOOP3 -> ignored; the run completes unchanged with a single done pulse.
